// File: rtl/transaction_control.sv
// Sequencing controller for the coin-transfer datapath: strobes amount/key, walks
// the ledger through balance and check words, writes balances back, holds the verdict.
`timescale 1ns/1ps
module transaction_control #(
  parameter int TIMEOUT = 16,
  parameter int SETTLE  = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        go,
  input  logic        done_step,
  input  logic [10:0] p1_amount_out,
  input  logic [10:0] p2_amount_out,
  output logic        load_amount,
  output logic        load_key,
  output logic [2:0]  mem_address,
  output logic        mem_write,
  output logic [10:0] mem_data,
  output logic        busy,
  output logic        accepted,
  output logic        rejected
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SETTLE_C     = CW'(SETTLE);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_AMT, S_LOAD_KEY, S_RD_P1, S_RD_P2, S_CHK_AMT, S_CHK_KEY, S_XFER,
    S_WB_P1, S_WB_P2, S_WB_MIR, S_DONE_OK, S_DONE_FAIL
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          go_q;
  logic          start;
  logic          load_amount_q, load_amount_d;
  logic          load_key_q, load_key_d;
  logic [2:0]    mem_address_q, mem_address_d;
  logic          mem_write_q, mem_write_d;
  logic [10:0]   mem_data_q, mem_data_d;
  logic          busy_q, busy_d;
  logic          accepted_q, accepted_d;
  logic          rejected_q, rejected_d;

  // The controller always supplies the ledger tag, so the datapath's tag bits are dropped.
  logic unused_tags;
  assign unused_tags = ^{p1_amount_out[10:8], p2_amount_out[10:8]};

  assign start = go & ~go_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE, S_DONE_OK, S_DONE_FAIL: if (start) state_d = S_LOAD_AMT;
      S_LOAD_AMT: state_d = S_LOAD_KEY;
      S_LOAD_KEY: state_d = S_RD_P1;
      S_RD_P1, S_RD_P2: begin
        if (cnt_q == SETTLE_LAST) state_d = (state_q == S_RD_P1) ? S_RD_P2 : S_CHK_AMT;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      // done_step is trusted only once the word for this address has settled.
      S_CHK_AMT, S_CHK_KEY, S_XFER: begin
        if (cnt_q >= SETTLE_C && done_step)
          state_d = (state_q == S_CHK_AMT) ? S_CHK_KEY :
                    (state_q == S_CHK_KEY) ? S_XFER : S_WB_P1;
        else if (cnt_q == TIMEOUT_LAST) state_d = S_DONE_FAIL;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      S_WB_P1:  state_d = S_WB_P2;
      S_WB_P2:  state_d = S_WB_MIR;
      S_WB_MIR: state_d = S_DONE_OK;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they are pure Moore.
  always_comb begin
    load_amount_d = (state_d == S_LOAD_AMT);
    load_key_d    = (state_d == S_LOAD_KEY);
    mem_address_d = 3'd3;
    mem_write_d   = 1'b0;
    mem_data_d    = '0;
    busy_d        = 1'b1;
    accepted_d    = accepted_q;
    rejected_d    = rejected_q;
    case (state_d)
      S_IDLE:     busy_d = 1'b0;
      S_LOAD_AMT: begin
        accepted_d = 1'b0;
        rejected_d = 1'b0;
      end
      S_RD_P2:    mem_address_d = 3'd4;
      S_CHK_AMT:  mem_address_d = 3'd0;
      S_CHK_KEY:  mem_address_d = 3'd1;
      S_XFER:     mem_address_d = 3'd2;
      S_WB_P1: begin
        mem_write_d = 1'b1;
        mem_data_d  = {3'b101, p1_amount_out[7:0]};
      end
      S_WB_P2: begin
        mem_write_d   = 1'b1;
        mem_address_d = 3'd4;
        mem_data_d    = {3'b110, p2_amount_out[7:0]};
      end
      S_WB_MIR: begin
        mem_write_d   = 1'b1;
        mem_address_d = 3'd0;
        mem_data_d    = {3'b001, p1_amount_out[7:0]};
      end
      S_DONE_OK: begin
        busy_d     = 1'b0;
        accepted_d = 1'b1;
      end
      S_DONE_FAIL: begin
        busy_d     = 1'b0;
        rejected_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      go_q          <= 1'b0;
      load_amount_q <= 1'b0;
      load_key_q    <= 1'b0;
      mem_address_q <= 3'd3;
      mem_write_q   <= 1'b0;
      mem_data_q    <= '0;
      busy_q        <= 1'b0;
      accepted_q    <= 1'b0;
      rejected_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      go_q          <= go;
      load_amount_q <= load_amount_d;
      load_key_q    <= load_key_d;
      mem_address_q <= mem_address_d;
      mem_write_q   <= mem_write_d;
      mem_data_q    <= mem_data_d;
      busy_q        <= busy_d;
      accepted_q    <= accepted_d;
      rejected_q    <= rejected_d;
    end
  end

  assign load_amount = load_amount_q;
  assign load_key    = load_key_q;
  assign mem_address = mem_address_q;
  assign mem_write   = mem_write_q;
  assign mem_data    = mem_data_q;
  assign busy        = busy_q;
  assign accepted    = accepted_q;
  assign rejected    = rejected_q;

endmodule

// File: tb/tb_transaction_control.sv
// Bench for transaction_control: vector table of whole transactions, directed corner
// sequences, and randomized go/done_step traffic against an interval-level model.
`timescale 1ns/1ps
module tb_transaction_control;
  localparam int TIMEOUT = 16;
  localparam int SETTLE  = 2;
  localparam int N       = 600;

  logic        clock = 1'b0;
  logic        resetn, go, done_step;
  logic [10:0] p1, p2;
  logic        load_amount, load_key, mem_write, busy, accepted, rejected;
  logic [2:0]  mem_address;
  logic [10:0] mem_data;

  transaction_control #(.TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
    .clock(clock), .resetn(resetn), .go(go), .done_step(done_step),
    .p1_amount_out(p1), .p2_amount_out(p2),
    .load_amount(load_amount), .load_key(load_key), .mem_address(mem_address),
    .mem_write(mem_write), .mem_data(mem_data), .busy(busy),
    .accepted(accepted), .rejected(rejected)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        la;
    logic        lk;
    logic [2:0]  addr;
    logic        we;
    logic [10:0] data;
    logic        busy;
    logic        acc;
    logic        rej;
  } outs_t;

  outs_t act;
  assign act = {load_amount, load_key, mem_address, mem_write, mem_data, busy, accepted, rejected};

  // delay codes per check: k>=0 pulse at wait count k, -1 never, -2 pulse at counts 0-1 only
  typedef struct {
    logic [10:0] p1;
    logic [10:0] p2;
    int          d0;
    int          d1;
    int          d2;
    bit          acc;
    bit          rej;
    int          cyc;
    int          nwr;
    logic [10:0] w0;
    logic [10:0] w1;
    logic [10:0] w2;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  vec_t  vecs [7];
  bit    go_a [N];
  bit    ds_a [N];
  outs_t exp_a [N];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic outs_t idle_o();
    outs_t o;
    o      = '0;
    o.addr = 3'd3;
    return o;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0; go = 1'b0; done_step = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit          dsr [128];
    int          dl [3];
    int          e, nwr, done_at, la_cnt;
    bit          both;
    logic [10:0] wd [3];
    logic [2:0]  wa [3];
    for (int i = 0; i < 128; i++) dsr[i] = 1'b0;
    for (int i = 0; i < 3; i++) begin wd[i] = '0; wa[i] = '0; end
    dl[0] = v.d0; dl[1] = v.d1; dl[2] = v.d2;
    e = 2 + 2 * SETTLE;
    for (int ph = 0; ph < 3; ph++) begin
      if (dl[ph] >= 0) begin
        dsr[e + dl[ph] + 1] = 1'b1;
        e = e + dl[ph] + 1;
      end else begin
        if (dl[ph] == -2) begin dsr[e + 1] = 1'b1; dsr[e + 2] = 1'b1; end
        break;
      end
    end
    @(negedge clock);
    go = 1'b0; done_step = 1'b0; p1 = v.p1; p2 = v.p2;
    @(negedge clock);
    chk($sformatf("vec%0d no_strobe_before_go", idx), 32'(load_amount), 32'd0);
    go = 1'b1;
    @(negedge clock);
    chk($sformatf("vec%0d start_latency", idx), 32'(load_amount), 32'd1);
    nwr = 0; done_at = -1; both = 1'b0; la_cnt = 0;
    for (int j = 0; j < 60; j++) begin
      if (load_amount) la_cnt++;
      if (mem_write) begin
        if (nwr < 3) begin wd[nwr] = mem_data; wa[nwr] = mem_address; end
        nwr++;
      end
      if (done_at < 0 && (accepted || rejected)) done_at = j;
      if (accepted && rejected) both = 1'b1;
      done_step = dsr[j + 1];
      @(negedge clock);
    end
    chk($sformatf("vec%0d accepted", idx), 32'(accepted), 32'(v.acc));
    chk($sformatf("vec%0d rejected", idx), 32'(rejected), 32'(v.rej));
    chk($sformatf("vec%0d result_cycle", idx), 32'(done_at), 32'(v.cyc));
    chk($sformatf("vec%0d write_count", idx), 32'(nwr), 32'(v.nwr));
    chk($sformatf("vec%0d busy_end", idx), 32'(busy), 32'd0);
    chk($sformatf("vec%0d both_flags", idx), 32'(both), 32'd0);
    chk($sformatf("vec%0d load_pulses", idx), 32'(la_cnt), 32'd1);
    if (v.nwr == 3) begin
      chk($sformatf("vec%0d wr0", idx), 32'({wa[0], wd[0]}), 32'({3'd3, v.w0}));
      chk($sformatf("vec%0d wr1", idx), 32'({wa[1], wd[1]}), 32'({3'd4, v.w1}));
      chk($sformatf("vec%0d wr2", idx), 32'({wa[2], wd[2]}), 32'({3'd0, v.w2}));
    end
    go = 1'b0; done_step = 1'b0;
  endtask

  function automatic bit ds_at(input int i);
    return (i < N) ? ds_a[i] : 1'b0;
  endfunction

  function automatic void mark(input int c, input logic [2:0] a);
    if (c < N) begin
      exp_a[c].busy = 1'b1; exp_a[c].addr = a;
      exp_a[c].acc  = 1'b0; exp_a[c].rej  = 1'b0;
    end
  endfunction

  function automatic void wb(input int c, input logic [2:0] a, input logic [10:0] d);
    mark(c, a);
    if (c < N) begin exp_a[c].we = 1'b1; exp_a[c].data = d; end
  endfunction

  // Reference: find each accepted go edge, then lay out the transaction's phases in time.
  task automatic build_model(input logic [10:0] p1v, input logic [10:0] p2v);
    int m, free, L, E, D, k;
    bit ok;
    for (int c = 0; c < N; c++) exp_a[c] = idle_o();
    free = 0; m = 1;
    while (m < N) begin
      if (go_a[m] && !go_a[m - 1] && (m - 1) >= free) begin
        L = m;
        mark(L, 3'd3);     if (L < N)     exp_a[L].la = 1'b1;
        mark(L + 1, 3'd3); if (L + 1 < N) exp_a[L + 1].lk = 1'b1;
        for (int j = 0; j < SETTLE; j++) begin
          mark(L + 2 + j, 3'd3);
          mark(L + 2 + SETTLE + j, 3'd4);
        end
        E = L + 2 + 2 * SETTLE; ok = 1'b1; D = 0;
        for (int ph = 0; ph < 3 && ok; ph++) begin
          k = SETTLE;
          while (k < TIMEOUT && !ds_at(E + k + 1)) k++;
          if (k < TIMEOUT) begin
            for (int j = 0; j <= k; j++) mark(E + j, 3'(ph));
            E = E + k + 1;
          end else begin
            for (int j = 0; j < TIMEOUT; j++) mark(E + j, 3'(ph));
            ok = 1'b0;
            D  = E + TIMEOUT;
          end
        end
        if (ok) begin
          wb(E,     3'd3, {3'b101, p1v[7:0]});
          wb(E + 1, 3'd4, {3'b110, p2v[7:0]});
          wb(E + 2, 3'd0, {3'b001, p1v[7:0]});
          D = E + 3;
        end
        for (int c = D; c < N; c++) begin exp_a[c].acc = ok; exp_a[c].rej = !ok; end
        free = D; m = D + 1;
      end else begin
        m++;
      end
    end
  endtask

  task automatic run_random(input int seg, input int pinv);
    logic [10:0] p1v, p2v;
    p1v = 11'($urandom); p2v = 11'($urandom);
    go_a[0] = 1'b0; ds_a[0] = 1'b0;
    for (int n = 1; n < N; n++) begin
      go_a[n] = ($urandom_range(7) == 0) ? !go_a[n - 1] : go_a[n - 1];
      ds_a[n] = ($urandom_range(pinv - 1) == 0);
    end
    build_model(p1v, p2v);
    do_reset();
    p1 = p1v; p2 = p2v; go = go_a[0]; done_step = ds_a[0];
    for (int n = 0; n < N; n++) begin
      @(negedge clock);
      chk($sformatf("rand seg%0d cyc%0d", seg, n), 32'(act), 32'(exp_a[n]));
      if (n + 1 < N) begin go = go_a[n + 1]; done_step = ds_a[n + 1]; end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int la_cnt, we_cnt;
    vecs[0] = '{11'h03C, 11'h064, 2, 2, 2,   1'b1, 1'b0, 18, 3, 11'h53C, 11'h664, 11'h13C};
    vecs[1] = '{11'h7FF, 11'h5AB, 2, 2, 2,   1'b1, 1'b0, 18, 3, 11'h5FF, 11'h6AB, 11'h1FF};
    vecs[2] = '{11'h000, 11'h0FF, 5, 3, 15,  1'b1, 1'b0, 35, 3, 11'h500, 11'h6FF, 11'h100};
    vecs[3] = '{11'h03C, 11'h064, 2, -1, 0,  1'b0, 1'b1, 25, 0, 11'h0, 11'h0, 11'h0};
    vecs[4] = '{11'h03C, 11'h064, -2, 0, 0,  1'b0, 1'b1, 22, 0, 11'h0, 11'h0, 11'h0};
    vecs[5] = '{11'h123, 11'h456, 2, 2, -1,  1'b0, 1'b1, 28, 0, 11'h0, 11'h0, 11'h0};
    vecs[6] = '{11'h0AA, 11'h055, 15, 2, 2,  1'b1, 1'b0, 31, 3, 11'h5AA, 11'h655, 11'h1AA};

    resetn = 1'b0; go = 1'b0; done_step = 1'b0; p1 = '0; p2 = '0;
    repeat (2) @(negedge clock);
    chk("reset_outputs", 32'(act), 32'(idle_o()));
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk($sformatf("idle_no_go %0d", i), 32'(act), 32'(idle_o()));
    end

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // go held high with extra edges while busy: one transaction only
    @(negedge clock);
    go = 1'b0; done_step = 1'b1; p1 = 11'h03C; p2 = 11'h064;
    repeat (2) @(negedge clock);
    la_cnt = 0; we_cnt = 0;
    for (int j = 0; j < 70; j++) begin
      if (j == 0) go = 1'b1;
      else if (j >= 4 && j < 12) go = j[0];
      else if (j >= 12) go = 1'b1;
      @(negedge clock);
      if (load_amount) la_cnt++;
      if (mem_write) we_cnt++;
    end
    chk("abuse load_pulses", 32'(la_cnt), 32'd1);
    chk("abuse write_pulses", 32'(we_cnt), 32'd3);
    chk("abuse accepted", 32'(accepted), 32'd1);
    chk("abuse busy", 32'(busy), 32'd0);

    // reset asserted while the second writeback word is on the bus
    go = 1'b0; done_step = 1'b1;
    repeat (2) @(negedge clock);
    go = 1'b1;
    @(negedge clock);
    repeat (16) @(negedge clock);
    chk("midwb wb_p2", 32'({mem_write, mem_address, mem_data}), 32'({1'b1, 3'd4, 11'h664}));
    #1 resetn = 1'b0;
    #1;
    chk("midwb async mem_write", 32'(mem_write), 32'd0);
    chk("midwb async outputs", 32'(act), 32'(idle_o()));
    @(negedge clock);
    go = 1'b0; done_step = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk($sformatf("midwb post_release %0d", i), 32'(act), 32'(idle_o()));
    end

    run_random(0, 2);
    run_random(1, 8);
    run_random(2, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/transaction_control.md
# transaction_control

Sequencing controller that sits directly upstream of the transaction datapath in the coin-transfer design. On a user `go` it strobes the amount and key registers. It then walks the ledger memory through a fixed address sequence so that the datapath sees balance, verify-amount, verify-key and complete-transaction words in order. It gates progress on `done_step` and writes the updated balances back to memory. It reports accept or reject and holds that result until the next transaction.

## Interface
Parameters:
- `TIMEOUT`, 16: max cycles to wait for `done_step` in a check state before rejecting (≥ SETTLE+1).
- `SETTLE`, 2: cycles after an address change before `done_step` is sampled (1 memory read latency + 1 datapath register).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `go`  in  1  user request, level; rising edge starts a transaction.
- `done_step`  in  1  step-complete flag from datapath.
- `p1_amount_out`  in  11  updated player-1 balance word from datapath.
- `p2_amount_out`  in  11  updated player-2 balance word from datapath.
- `load_amount`  out  1  one-cycle strobe to datapath amount register.
- `load_key`  out  1  one-cycle strobe to datapath key register.
- `mem_address`  out  3  ledger memory address.
- `mem_write`  out  1  ledger write enable.
- `mem_data`  out  11  ledger write data.
- `busy`  out  1  transaction in progress.
- `accepted`  out  1  last transaction committed.
- `rejected`  out  1  last transaction failed or timed out.

## Operation
Ledger map; tag = bits [10:8]:
- 0: amount-check word, tag 001.
- 1: key word, tag 010.
- 2: complete word, tag 100.
- 3: P1 balance, tag 101.
- 4: P2 balance, tag 110.

Edge detection: a one-flop register of `go`; start = `go & ~go_q`. Start is ignored unless the state is IDLE or a DONE state.

State sequence:
- IDLE / DONE_OK / DONE_FAIL → LOAD_AMT on start.
  - Entering LOAD_AMT clears `accepted` and `rejected`.
- LOAD_AMT: `load_amount`=1 for one cycle → LOAD_KEY.
- LOAD_KEY: `load_key`=1 for one cycle → RD_P1.
- RD_P1: addr 3, held SETTLE cycles → RD_P2.
- RD_P2: addr 4, held SETTLE cycles → CHK_AMT.
- CHK_AMT: addr 0 → CHK_KEY.
- CHK_KEY: addr 1 → XFER.
- XFER: addr 2 → WB_P1.
- Check states (CHK_AMT, CHK_KEY, XFER):
  - A wait counter resets on entry and increments each cycle.
  - `done_step` is sampled only when counter ≥ SETTLE.
  - If `done_step`=1, advance.
  - If the counter reaches TIMEOUT with no `done_step`, go to DONE_FAIL.
- WB_P1: `mem_write`=1, addr 3, data {3'b101, p1_amount_out[7:0]} → WB_P2.
- WB_P2: `mem_write`=1, addr 4, data {3'b110, p2_amount_out[7:0]} → WB_MIR.
- WB_MIR: `mem_write`=1, addr 0, data {3'b001, p1_amount_out[7:0]} → DONE_OK.
- DONE_OK sets `accepted`. DONE_FAIL sets `rejected`.

Output rules:
- `busy` = 1 in every state except IDLE, DONE_OK and DONE_FAIL.
- `mem_write` is asserted only in WB states.
- Outside WB states, `mem_data` = 0.
- In IDLE and DONE states, `mem_address` = 3, so the P1 balance stays visible.
- The tag is always forced by the controller. Bits [10:8] of the `p*_amount_out` inputs are ignored.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, except `mem_address`=3.
  - Counter 0; `go_q` 0.
- Reset takes effect immediately, including mid-write: `mem_write` drops asynchronously and no further WB state is entered.
- All outputs are registered (Moore), so they change only on `clock` rising edges, apart from reset.
- Start latency: `load_amount` is high in the cycle after the edge of `go` is sampled.
- Minimum accepted transaction, with `done_step` high at the first legal sample in each check, counts 2+2·SETTLE+3·(SETTLE+1)+3 cycles from LOAD_AMT entry to DONE_OK entry. That is 18 cycles at SETTLE=2.
- `done_step` high before counter=SETTLE is ignored, because stale words are still in flight.
- `go` held high does not retrigger; it must fall and rise again.
- `go` edges while `busy` are discarded, not queued.
- `accepted` and `rejected` are never both 1.

## Test plan
- Reset then idle:
  - Stimulus: `resetn`=0 for 3 cycles, then release.
  - Required: all outputs 0 except `mem_address`=3; `busy`=0.
  - No `load_*` strobe until a `go` edge arrives.
- Happy path:
  - Stimulus: `go` edge; memory model returns tagged words; `done_step`=1 at each first legal sample; p1_amount_out=0x0_3C, p2_amount_out=0x0_64.
  - Required: writes 0x53C→addr 3, 0x664→addr 4, 0x13C→addr 0 on consecutive cycles.
  - Required: `accepted`=1 at cycle 18 after LOAD_AMT; `busy`=0.
- Key failure:
  - Stimulus: `done_step` never rises in CHK_KEY.
  - Required: `rejected`=1 exactly TIMEOUT cycles after CHK_KEY entry; zero `mem_write` pulses.
- Early `done_step`:
  - Stimulus: `done_step`=1 only at counter 0–1 of CHK_AMT.
  - Required: no advance; timeout leads to DONE_FAIL.
- `go` abuse:
  - Stimulus: `go` held high for 40 cycles, plus extra edges during `busy`.
  - Required: exactly one transaction; `load_amount` pulses exactly once.
- Reset mid-writeback:
  - Stimulus: assert `resetn`=0 during WB_P2.
  - Required: `mem_write` falls with no clock edge; state IDLE; `accepted`=0 after release.
